// File: rtl/pio_saida_arbiter.sv
// Round-robin arbiter letting the Nios II data master (m0) and the RANSAC status
// writer (m1) share one zero-latency Avalon-MM PIO output slave.
//
// state | meaning
// IDLE  | no grant; slave bus parked; pick next master
// GNT0  | m0 owns the slave for exactly one cycle
// GNT1  | m1 owns the slave for exactly one cycle
module pio_saida_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_chipselect,
    input  logic              m0_write_n,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_chipselect,
    input  logic              m1_write_n,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_chipselect,
    output logic              s_write_n,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,
    output logic [1:0]        grant,
    output logic              contention
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;       // 1 = m1 was served last
    logic [1:0]  grant_q, grant_d;
    logic        contention_q, contention_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            grant_q      <= 2'b00;
            contention_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
            contention_q <= contention_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        contention_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_chipselect && m1_chipselect) begin
                    contention_d = 1'b1;
                    state_d      = last_q ? GNT0 : GNT1;
                end else if (m0_chipselect) begin
                    state_d = GNT0;
                end else if (m1_chipselect) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                last_d  = 1'b0;
                state_d = IDLE;
            end
            GNT1: begin
                last_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        grant_d = {state_d == GNT1, state_d == GNT0};
    end

    // Slave bus is a pure mux of the granted master; parked values outside a grant.
    always_comb begin
        s_address    = '0;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        s_writedata  = '0;
        m0_readdata  = '0;
        m1_readdata  = '0;
        case (state_q)
            GNT0: begin
                s_address    = m0_address;
                s_chipselect = m0_chipselect;
                s_write_n    = m0_write_n;
                s_writedata  = m0_writedata;
                m0_readdata  = s_readdata;
            end
            GNT1: begin
                s_address    = m1_address;
                s_chipselect = m1_chipselect;
                s_write_n    = m1_write_n;
                s_writedata  = m1_writedata;
                m1_readdata  = s_readdata;
            end
            default: ;
        endcase
    end

    assign m0_waitrequest = m0_chipselect && (state_q != GNT0);
    assign m1_waitrequest = m1_chipselect && (state_q != GNT1);
    assign grant          = grant_q;
    assign contention     = contention_q;

endmodule

// File: tb/tb_pio_saida_arbiter.sv
// Bench for pio_saida_arbiter: vector table with a scoreboard queue, a 1-bit PIO
// slave model, and hand sequences for reset-mid-grant and sustained contention.
module tb_pio_saida_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              pio_clr_n = 1'b0;
    logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
    logic              m0_chipselect = 1'b0, m1_chipselect = 1'b0;
    logic              m0_write_n = 1'b1, m1_write_n = 1'b1;
    logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [ADDR_W-1:0] s_address;
    logic              s_chipselect, s_write_n;
    logic [DATA_W-1:0] s_writedata, s_readdata;
    logic [1:0]        grant;
    logic              contention;
    logic              out_port;

    always #5 clk = ~clk;

    pio_saida_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_chipselect(m0_chipselect), .m0_write_n(m0_write_n),
        .m0_writedata(m0_writedata), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_chipselect(m1_chipselect), .m1_write_n(m1_write_n),
        .m1_writedata(m1_writedata), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
        .s_writedata(s_writedata), .s_readdata(s_readdata),
        .grant(grant), .contention(contention)
    );

    // PIO slave model: independent clear so an arbiter reset does not disturb it.
    always_ff @(posedge clk or negedge pio_clr_n) begin
        if (!pio_clr_n)
            out_port <= 1'b0;
        else if (s_chipselect && !s_write_n && s_address == '0)
            out_port <= s_writedata[0];
    end
    assign s_readdata = {{(DATA_W-1){1'b0}}, out_port};

    typedef struct {
        logic        rst;
        logic        c0; logic w0; logic [31:0] d0;
        logic        c1; logic w1; logic [31:0] d1;
        logic        ew0; logic ew1;
        logic        ecs; logic ewn; logic [31:0] ewd;
        logic [1:0]  eg; logic ec;
        logic [31:0] er0; logic [31:0] er1;
        logic        ep;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];
    vec_t sbq[$];

    function automatic vec_t mk(logic rst, logic c0, logic w0, logic [31:0] d0,
                                logic c1, logic w1, logic [31:0] d1,
                                logic ew0, logic ew1, logic ecs, logic ewn, logic [31:0] ewd,
                                logic [1:0] eg, logic ec, logic [31:0] er0, logic [31:0] er1,
                                logic ep);
        vec_t v;
        v.rst = rst; v.c0 = c0; v.w0 = w0; v.d0 = d0; v.c1 = c1; v.w1 = w1; v.d1 = d1;
        v.ew0 = ew0; v.ew1 = ew1; v.ecs = ecs; v.ewn = ewn; v.ewd = ewd;
        v.eg = eg; v.ec = ec; v.er0 = er0; v.er1 = er1; v.ep = ep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        m0_chipselect = 1'b0; m0_write_n = 1'b1; m0_writedata = '0;
        m1_chipselect = 1'b0; m1_write_n = 1'b1; m1_writedata = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v, e;
        int   lg, ms, cnt0, cnt1;
        logic [1:0] eg;

        // single write by m0
        vecs.push_back(mk(1, 1,0,1, 0,1,0, 1,0, 0,1,0, 2'b00,0, 0,0, 0));
        vecs.push_back(mk(0, 1,0,1, 0,1,0, 0,0, 1,0,1, 2'b01,0, 0,0, 0));
        vecs.push_back(mk(0, 0,1,0, 0,1,0, 0,0, 0,1,0, 2'b00,0, 0,0, 1));
        // simultaneous after reset: m0 writes 1, m1 writes 0
        vecs.push_back(mk(1, 1,0,1, 1,0,0, 1,1, 0,1,0, 2'b00,0, 0,0, 1));
        vecs.push_back(mk(0, 1,0,1, 1,0,0, 0,1, 1,0,1, 2'b01,1, 1,0, 1));
        vecs.push_back(mk(0, 0,1,0, 1,0,0, 0,1, 0,1,0, 2'b00,0, 0,0, 1));
        vecs.push_back(mk(0, 0,1,0, 1,0,0, 0,0, 1,0,0, 2'b10,0, 0,1, 1));
        vecs.push_back(mk(0, 0,1,0, 0,1,0, 0,0, 0,1,0, 2'b00,0, 0,0, 0));
        // m1 writes 1 then reads it back
        vecs.push_back(mk(0, 0,1,0, 1,0,1, 0,1, 0,1,0, 2'b00,0, 0,0, 0));
        vecs.push_back(mk(0, 0,1,0, 1,0,1, 0,0, 1,0,1, 2'b10,0, 0,0, 0));
        vecs.push_back(mk(0, 0,1,0, 1,1,0, 0,1, 0,1,0, 2'b00,0, 0,0, 1));
        vecs.push_back(mk(0, 0,1,0, 1,1,0, 0,0, 1,1,0, 2'b10,0, 0,1, 1));
        vecs.push_back(mk(0, 0,1,0, 0,1,0, 0,0, 0,1,0, 2'b00,0, 0,0, 1));
        // m1 retracts its write of 0 in the grant cycle
        vecs.push_back(mk(0, 0,1,0, 1,0,0, 0,1, 0,1,0, 2'b00,0, 0,0, 1));
        vecs.push_back(mk(0, 0,1,0, 0,1,0, 0,0, 0,1,0, 2'b10,0, 0,1, 1));
        vecs.push_back(mk(0, 0,1,0, 0,1,0, 0,0, 0,1,0, 2'b00,0, 0,0, 1));

        drive_idle();
        reset_n = 1'b0; pio_clr_n = 1'b0;
        #12;
        pio_clr_n = 1'b1;
        @(negedge clk);
        chk("reset_grant", {30'b0, grant}, 32'h0);
        chk("reset_contention", {31'b0, contention}, 32'h0);
        chk("reset_s_cs", {31'b0, s_chipselect}, 32'h0);
        chk("reset_s_wn", {31'b0, s_write_n}, 32'h1);
        chk("reset_s_wdata", s_writedata, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            v = vecs[i];
            if (v.rst) do_reset();
            m0_chipselect = v.c0; m0_write_n = v.w0; m0_writedata = v.d0;
            m1_chipselect = v.c1; m1_write_n = v.w1; m1_writedata = v.d1;
            sbq.push_back(v);
            @(negedge clk);
            e = sbq.pop_front();
            chk($sformatf("v%0d_m0_wait", i), {31'b0, m0_waitrequest}, {31'b0, e.ew0});
            chk($sformatf("v%0d_m1_wait", i), {31'b0, m1_waitrequest}, {31'b0, e.ew1});
            chk($sformatf("v%0d_s_cs", i), {31'b0, s_chipselect}, {31'b0, e.ecs});
            chk($sformatf("v%0d_s_wn", i), {31'b0, s_write_n}, {31'b0, e.ewn});
            chk($sformatf("v%0d_s_wdata", i), s_writedata, e.ewd);
            chk($sformatf("v%0d_grant", i), {30'b0, grant}, {30'b0, e.eg});
            chk($sformatf("v%0d_contention", i), {31'b0, contention}, {31'b0, e.ec});
            chk($sformatf("v%0d_m0_rdata", i), m0_readdata, e.er0);
            chk($sformatf("v%0d_m1_rdata", i), m1_readdata, e.er1);
            chk($sformatf("v%0d_out_port", i), {31'b0, out_port}, {31'b0, e.ep});
            @(posedge clk);
            #1;
        end

        // reset asserted during GNT1 of an m1 write of 0 (out_port is 1)
        m1_chipselect = 1'b1; m1_write_n = 1'b0; m1_writedata = 32'h0;
        @(negedge clk);
        chk("rst_mid_pre_wait", {31'b0, m1_waitrequest}, 32'h1);
        @(posedge clk);
        #1;
        chk("rst_mid_gnt1_cs", {31'b0, s_chipselect}, 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_cs_drop", {31'b0, s_chipselect}, 32'h0);
        chk("rst_mid_grant", {30'b0, grant}, 32'h0);
        chk("rst_mid_idle_wait", {31'b0, m1_waitrequest}, 32'h1);
        @(posedge clk);
        #1;
        chk("rst_mid_no_write", {31'b0, out_port}, 32'h1);
        m0_chipselect = 1'b1; m0_write_n = 1'b0; m0_writedata = 32'h1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_tie_idle_grant", {30'b0, grant}, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_tie_m0_first", {30'b0, grant}, 32'h1);
        chk("rst_tie_contention", {31'b0, contention}, 32'h1);

        // sustained contention: grants must strictly alternate starting with m0
        do_reset();
        m0_chipselect = 1'b1; m0_write_n = 1'b0; m0_writedata = 32'h1;
        m1_chipselect = 1'b1; m1_write_n = 1'b0; m1_writedata = 32'h0;
        lg = 1; ms = 0; cnt0 = 0; cnt1 = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            eg = (ms == 1) ? 2'b01 : (ms == 2) ? 2'b10 : 2'b00;
            chk($sformatf("sus%0d_grant", k), {30'b0, grant}, {30'b0, eg});
            if (m0_chipselect && !m0_waitrequest) cnt0++;
            if (m1_chipselect && !m1_waitrequest) cnt1++;
            if (ms == 0) begin
                ms = (lg == 1) ? 1 : 2;
            end else begin
                lg = (ms == 2) ? 1 : 0;
                ms = 0;
            end
            @(posedge clk);
            #1;
        end
        chk("sus_m0_transfers", cnt0, 32'd4);
        chk("sus_m1_transfers", cnt1, 32'd4);
        drive_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
